adlv_resolve_seq: RTL and testbench
===================================

// Module: adlv_resolve_seq
// PURPOSE
//  Downstream stage of the 23-bit two-vector adder cell chain. Accepts a sum vector and a
//  carry vector and resolves them into one binary result: s_in + (e_in << 1).
//  Works CHUNK bits per cycle, ripple-style, so area stays small.
//  Uses a valid/ready handshake on both sides; sits between the cell-chain adder and the
//  consuming datapath register.
// PARAMETERS
//  W      23  width of s_in / e_in (BIT + SPA of the upstream adder)
//  CHUNK  4   bits resolved per cycle; legal range 1..W+1
//  NCH    ceil((W+1)/CHUNK) = 6  localparam: number of RUN cycles
// PORTS
//  clk        in   1     rising-edge clock
//  rst_n      in   1     synchronous reset, active low
//  in_valid   in   1     s_in/e_in are valid
//  in_ready   out  1     stage can accept an operand pair
//  s_in       in   W     sum vector from the upstream adder
//  e_in       in   W     carry vector from the upstream adder; weight 2^(i+1) for bit i
//  out_valid  out  1     result is valid
//  out_ready  in   1     downstream accepts the result
//  result     out  W+2   s_in + (e_in << 1), full precision, never truncated
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge):
//    state=IDLE, in_ready=1, out_valid=0, result=0, internal carry=0, chunk index=0.
//    Reset mid-RUN/DONE aborts the operation; no partial result is ever flagged valid.
//  - FSM IDLE -> RUN -> DONE -> IDLE:
//    IDLE: in_ready=1. On in_valid&in_ready, capture A={1'b0,s_in} and B={e_in,1'b0}
//          (W+1 bits each), clear carry and idx, go to RUN.
//    RUN:  in_ready=0. Each cycle add A[idx*CHUNK +: CHUNK] + B[idx*CHUNK +: CHUNK] + carry.
//          Write the low CHUNK bits into result, keep the carry-out, increment idx.
//          The last chunk is masked to (W+1) - (NCH-1)*CHUNK bits.
//          After chunk NCH-1, write the final carry into result[W+1] and go to DONE.
//    DONE: out_valid=1. result is held stable until out_valid&out_ready, then return to IDLE.
//          In that IDLE cycle out_valid=0.
//  - Latency: handshake at cycle t gives out_valid at t+NCH+1 (7 cycles at the defaults).
//    Throughput is one result per NCH+2 cycles when out_ready is held high.
//  - in_ready is combinational from state only (state==IDLE), never from in_valid.
//  - in_valid seen while not IDLE is ignored; upstream must hold its data until accepted.
//  - out_ready while out_valid=0 has no effect.
//  - result bits not yet written during RUN keep their previous values. They are
//    meaningful only while out_valid=1.
// CONFIGURATION
//  ADLV_RESOLVE_STATS_EN defined:
//   - Adds output err_cnt [15:0]. It increments on every accepted pair with e_in != 0,
//     saturates at 16'hFFFF and resets to 0 on rst_n=0.
//   - Adds input cnt_clr, which zeroes the counter synchronously. If cnt_clr and an
//     increment coincide, clear wins.
//  ADLV_RESOLVE_STATS_EN undefined: no err_cnt/cnt_clr ports and no counter logic.
// STRUCTURE
//  - Shared package/header: ADLV_W=23, ADLV_SPA=4, ADLV_CHUNK default, and the state
//    encoding ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//  - One sub-module, adlv_chunk_add: CHUNK-bit adder with carry in/out, built from the
//    cell primitive where CHUNK permits.
//  - Top level holds the FSM, operand registers, idx counter, carry flop and result register.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles -> in_ready=1, out_valid=0, result=0.
//  2 s=23'h000001, e=23'h000001 -> result=25'h0000003, out_valid exactly 7 cycles after
//    the accepting edge.
//  3 s=23'h7FFFFF, e=23'h7FFFFF -> result=25'h17FFFFD (checks carry into result[24]).
//    Then s=23'h7FFFFF, e=23'h400000 -> result=25'h0FFFFFF.
//  4 Backpressure: out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0, and a new
//    in_valid is not taken. out_ready=1 -> IDLE next cycle, then accepts the next pair.
//  5 Reset mid-operation: rst_n=0 in RUN cycle 3 -> IDLE next cycle, out_valid never rises.
//  6 STATS_EN: 3 pairs with e!=0 and 1 pair with e=0 -> err_cnt=3. cnt_clr with a
//    concurrent increment -> err_cnt=0. Random 1000-pair run checked against a reference sum.

Source files
------------

// File: rtl/adlv_resolve_seq_pkg.sv
// Shared constants and state encoding for the chunked sum/carry resolver.
package adlv_resolve_seq_pkg;

  localparam int unsigned ADLV_W     = 23;
  localparam int unsigned ADLV_SPA   = 4;
  localparam int unsigned ADLV_CHUNK = ADLV_SPA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } adlv_state_t;

  // Number of RUN cycles needed to cover w+1 operand bits: ceil((w+1)/chunk).
  function automatic int unsigned adlv_nch(input int unsigned w, input int unsigned chunk);
    return (w + chunk) / chunk;
  endfunction

endpackage

// File: rtl/adlv_chunk_add.sv
// CHUNK-bit ripple adder built from full-adder cells, with carry in/out.
module adlv_chunk_add
  import adlv_resolve_seq_pkg::*;
#(
  parameter int unsigned CHUNK = ADLV_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_cell
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/adlv_resolve_seq.sv
// Resolves a sum/carry vector pair into s_in + (e_in << 1), CHUNK bits per cycle.
// Optional error-pair counter enabled by defining ADLV_RESOLVE_STATS_EN.
module adlv_resolve_seq
  import adlv_resolve_seq_pkg::*;
#(
  parameter int unsigned W     = ADLV_W,
  parameter int unsigned CHUNK = ADLV_CHUNK
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] s_in,
  input  logic [W-1:0] e_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W+1:0] result
`ifdef ADLV_RESOLVE_STATS_EN
  ,
  input  logic         cnt_clr,
  output logic [15:0]  err_cnt
`endif
);

  localparam int unsigned NCH  = adlv_nch(W, CHUNK);
  localparam int unsigned OPW  = NCH * CHUNK;
  localparam int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned BW   = $clog2(OPW + 1);

  adlv_state_t      state_q;
  adlv_state_t      state_d;
  logic [OPW-1:0]   a_q;
  logic [OPW-1:0]   b_q;
  logic [OPW:0]     res_q;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic [BW-1:0]    base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] sum_chunk;
  logic             cout_chunk;
  logic             accept;
  logic             last_chunk;

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign accept     = in_valid & in_ready;
  assign last_chunk = (idx_q == IDXW'(NCH - 1));
  assign base       = BW'(32'(idx_q) * CHUNK);
  assign a_chunk    = a_q[base +: CHUNK];
  assign b_chunk    = b_q[base +: CHUNK];
  // Operands are zero-padded to NCH*CHUNK bits, which masks the short last chunk;
  // its carry then lands in bit W+1 either as a sum bit or via the carry write.
  assign result     = res_q[W+1:0];

  adlv_chunk_add #(
    .CHUNK(CHUNK)
  ) u_chunk_add (
    .a   (a_chunk),
    .b   (b_chunk),
    .cin (carry_q),
    .sum (sum_chunk),
    .cout(cout_chunk)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid)   state_d = ST_RUN;
      ST_RUN:  if (last_chunk) state_d = ST_DONE;
      ST_DONE: if (out_ready)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture and per-chunk result accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      a_q     <= OPW'({1'b0, s_in});
      b_q     <= OPW'({e_in, 1'b0});
      idx_q   <= '0;
      carry_q <= 1'b0;
    end else if (state_q == ST_RUN) begin
      res_q[base +: CHUNK] <= sum_chunk;
      carry_q              <= cout_chunk;
      idx_q                <= idx_q + IDXW'(1);
      if (last_chunk) begin
        res_q[OPW] <= cout_chunk;
      end
    end
  end

`ifdef ADLV_RESOLVE_STATS_EN
  // Saturating count of accepted pairs carrying a non-zero carry vector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= 16'h0000;
    end else if (cnt_clr) begin
      err_cnt <= 16'h0000;
    end else if (accept && (e_in != '0) && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adlv_resolve_seq.sv
// Self-checking bench for adlv_resolve_seq: directed corners plus a randomized run
// against an arithmetic reference. Covers the counter when ADLV_RESOLVE_STATS_EN is defined.
module tb_adlv_resolve_seq;
  import adlv_resolve_seq_pkg::*;

  localparam int unsigned W   = ADLV_W;
  localparam int unsigned NCH = adlv_nch(ADLV_W, ADLV_CHUNK);

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] s_in;
  logic [W-1:0] e_in;
  logic         out_valid;
  logic         out_ready;
  logic [W+1:0] result;
`ifdef ADLV_RESOLVE_STATS_EN
  logic         cnt_clr;
  logic [15:0]  err_cnt;
  int unsigned  exp_cnt;
`endif

  int n_checks;
  int n_pass;

  adlv_resolve_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s_in     (s_in),
    .e_in     (e_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
`ifdef ADLV_RESOLVE_STATS_EN
    ,
    .cnt_clr  (cnt_clr),
    .err_cnt  (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: the value the pair represents, in full precision.
  function automatic logic [W+1:0] ref_sum(input logic [W-1:0] s, input logic [W-1:0] e);
    return (W+2)'(s) + ((W+2)'(e) * (W+2)'(2));
  endfunction

  task automatic do_op(input logic [W-1:0] s, input logic [W-1:0] e, input int stall, input bit clr);
    int n;
    int lat;
    logic [W+1:0] held;
    @(negedge clk);
    in_valid  = 1'b1;
    s_in      = s;
    e_in      = e;
    out_ready = 1'b0;
`ifdef ADLV_RESOLVE_STATS_EN
    cnt_clr = clr;
`endif
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    s_in     = W'($urandom);
    e_in     = W'($urandom);
`ifdef ADLV_RESOLVE_STATS_EN
    cnt_clr = 1'b0;
    if (clr) exp_cnt = 0;
    else if (e != '0 && exp_cnt < 65535) exp_cnt++;
`endif
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    check("latency", 64'(lat), 64'(NCH + 1));
    check("result", 64'(result), 64'(ref_sum(s, e)));
    check("in_ready_done", 64'(in_ready), 64'd0);
`ifdef ADLV_RESOLVE_STATS_EN
    check("err_cnt", 64'(err_cnt), 64'(exp_cnt));
`endif
    held = result;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      s_in     = W'($urandom);
      e_in     = W'($urandom) | W'(1);
      @(negedge clk);
      check("hold_result", 64'(result), 64'(held));
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
`ifdef ADLV_RESOLVE_STATS_EN
      check("hold_err_cnt", 64'(err_cnt), 64'(exp_cnt));
`endif
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("idle_out_valid", 64'(out_valid), 64'd0);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
  endtask

  task automatic abort_op(input logic [W-1:0] s, input logic [W-1:0] e);
    int seen;
    @(negedge clk);
    in_valid = 1'b1;
    s_in     = s;
    e_in     = e;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`ifdef ADLV_RESOLVE_STATS_EN
    exp_cnt = 0;
    check("abort_err_cnt", 64'(err_cnt), 64'd0);
`endif
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    seen = 0;
    out_ready = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    check("abort_no_valid", 64'(seen), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rs;
    logic [W-1:0] re;
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    s_in      = '0;
    e_in      = '0;
`ifdef ADLV_RESOLVE_STATS_EN
    cnt_clr = 1'b0;
    exp_cnt = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    rst_n = 1'b1;

    do_op(23'h000001, 23'h000001, 0, 1'b0);
    check("small_sum", 64'(result), 64'h3);
    do_op(23'h7FFFFF, 23'h7FFFFF, 0, 1'b0);
    check("top_carry", 64'(result), 64'h17FFFFD);
    do_op(23'h7FFFFF, 23'h400000, 0, 1'b0);
    check("no_top_carry", 64'(result), 64'h0FFFFFF);
    do_op(23'h123456, 23'h654321, 5, 1'b0);
    do_op(23'h000000, 23'h000000, 0, 1'b0);

    abort_op(23'h2AAAAA, 23'h555555);

`ifdef ADLV_RESOLVE_STATS_EN
    do_op(23'h000010, 23'h000001, 0, 1'b0);
    do_op(23'h000020, 23'h000000, 0, 1'b0);
    do_op(23'h000030, 23'h400000, 0, 1'b0);
    do_op(23'h000040, 23'h0F0F0F, 0, 1'b0);
    check("err_cnt_three", 64'(err_cnt), 64'd3);
    do_op(23'h000050, 23'h000002, 0, 1'b1);
    check("err_cnt_clr_wins", 64'(err_cnt), 64'd0);
`endif

    for (int k = 0; k < 1000; k++) begin
      rs = W'($urandom);
      re = W'($urandom);
      if ($urandom_range(0, 7) == 0) re = '0;
      if ($urandom_range(0, 15) == 0) rs = '1;
      do_op(rs, re, int'($urandom_range(0, 2)), ($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
